// File: rtl/ping_pong_display_if.sv
// Display-side bus between the ping-pong counter and the seven-segment driver.
// The master supplies value/direction/enable; the slave drives the anodes and segments.
interface ping_pong_display_if;
    logic [3:0] value;
    logic       direction;
    logic       display_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output value,
        output direction,
        output display_en,
        input  an,
        input  seg,
        input  dp
    );

    modport slave (
        input  value,
        input  direction,
        input  display_en,
        output an,
        output seg,
        output dp
    );
endinterface

// File: rtl/ping_pong_display.sv
// Four-digit common-anode display for the ping-pong counter: decimal value on the right two
// digits, a direction arrow on the left two, inputs snapshotted once per frame.
module ping_pong_display #(
    parameter int unsigned DWELL_BITS = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    ping_pong_display_if.slave bus
);
    localparam logic [DWELL_BITS-1:0] DwellOne = DWELL_BITS'(1);
    localparam logic [6:0] SegZero  = 7'b1000000;
    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegUp    = 7'b0011100;
    localparam logic [6:0] SegDown  = 7'b0100011;

    logic [DWELL_BITS-1:0] r_dwell_cnt;
    logic [1:0]            r_digit_idx;
    logic [3:0]            r_sh_value;
    logic                  r_sh_dir;
    logic [3:0]            r_an;
    logic [6:0]            r_seg;

    logic       w_dwell_wrap;
    logic       w_frame_end;
    logic       w_tens;
    logic [3:0] w_ones;
    logic [3:0] w_an_next;
    logic [6:0] w_seg_next;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SegBlank;
        endcase
        return code;
    endfunction

    assign w_dwell_wrap = &r_dwell_cnt;
    assign w_frame_end  = w_dwell_wrap && (r_digit_idx == 2'd3);

    // A 4-bit value never exceeds 15, so one conditional subtract gives mod 10.
    assign w_tens = (r_sh_value >= 4'd10);
    assign w_ones = w_tens ? (r_sh_value - 4'd10) : r_sh_value;

    always_comb begin
        w_seg_next = SegBlank;
        unique case (r_digit_idx)
            2'd0:    w_seg_next = digit_to_seg(w_ones);
            2'd1:    w_seg_next = w_tens ? digit_to_seg(4'd1) : SegBlank;
            default: w_seg_next = r_sh_dir ? SegUp : SegDown;
        endcase
    end

    always_comb begin
        w_an_next = 4'b1111;
        if (bus.display_en) begin
            w_an_next = ~(4'b0001 << r_digit_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell_cnt <= '0;
            r_digit_idx <= 2'd0;
            r_sh_value  <= 4'd0;
            r_sh_dir    <= 1'b1;
            r_an        <= 4'b1110;
            r_seg       <= SegZero;
        end else begin
            r_dwell_cnt <= r_dwell_cnt + DwellOne;
            if (w_dwell_wrap) begin
                r_digit_idx <= r_digit_idx + 2'd1;
            end
            // Capture only at the frame boundary so one frame never mixes old and new inputs.
            if (w_frame_end) begin
                r_sh_value <= bus.value;
                r_sh_dir   <= bus.direction;
            end
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = 1'b1;
endmodule

// File: tb/tb_ping_pong_display.sv
// Randomized bench for ping_pong_display with a time-based reference model: the digit shown
// and the frame snapshot are derived from the count of clock edges since reset.
module tb_ping_pong_display;
    localparam int unsigned DwellBits = 2;
    localparam int Dwell = 1 << DwellBits;
    localparam int Frame = 4 * Dwell;

    localparam logic [6:0] Blank = 7'b1111111;
    localparam logic [6:0] Up    = 7'b0011100;
    localparam logic [6:0] Down  = 7'b0100011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ping_pong_display_if ifc ();

    ping_pong_display #(
        .DWELL_BITS(DwellBits)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: edges since reset release and the value/direction held for the current frame.
    int m_edges    = 0;
    int m_sh_value = 0;
    bit m_sh_dir   = 1'b1;

    function automatic logic [6:0] numeral(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return Blank;
        endcase
    endfunction

    function automatic logic [6:0] expect_seg(input int idx, input int v, input bit d);
        if (idx == 0) return numeral(v % 10);
        if (idx == 1) return (v / 10 == 0) ? Blank : numeral(v / 10);
        return d ? Up : Down;
    endfunction

    // One clock edge; returns what an/seg must read just after it.
    task automatic tick(output logic [3:0] ea, output logic [6:0] es);
        int idx;
        int pv;
        bit pd;
        bit pe;
        pv  = int'(ifc.value);
        pd  = ifc.direction;
        pe  = ifc.display_en;
        idx = (m_edges / Dwell) % 4;
        ea  = pe ? 4'(~(1 << idx)) : 4'b1111;
        es  = expect_seg(idx, m_sh_value, m_sh_dir);
        @(posedge clk);
        #1;
        m_edges++;
        if (m_edges % Frame == 0) begin
            m_sh_value = pv;
            m_sh_dir   = pd;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        m_edges    = 0;
        m_sh_value = 0;
        m_sh_dir   = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] ea;
        logic [6:0] es;
        do_reset();
        ifc.value      = 4'd9;
        ifc.direction  = 1'b0;
        ifc.display_en = 1'b1;
        repeat (Frame + 6) begin
            tick(ea, es);
            n_checks++;
            if (ifc.an !== ea || ifc.seg !== es) begin
                n_errors++;
                $display("FAIL reset_pre: an=%b seg=%b expected an=%b seg=%b", ifc.an, ifc.seg, ea, es);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ifc.an !== 4'b1110 || ifc.seg !== 7'b1000000 || ifc.dp !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_async: an=%b seg=%b dp=%b expected 1110 1000000 1", ifc.an, ifc.seg,
                     ifc.dp);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ifc.an !== 4'b1110 || ifc.seg !== 7'b1000000) begin
            n_errors++;
            $display("FAIL reset_hold: an=%b seg=%b expected 1110 1000000", ifc.an, ifc.seg);
        end
        rst_n      = 1'b1;
        m_edges    = 0;
        m_sh_value = 0;
        m_sh_dir   = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(ea, es);
            n_checks++;
            if (ifc.an !== ea || ifc.seg !== es) begin
                n_errors++;
                $display("FAIL reset_release_%0d: an=%b seg=%b expected an=%b seg=%b", k, ifc.an,
                         ifc.seg, ea, es);
            end
            if (k == 4 || k == 5) begin
                n_checks++;
                if (ifc.an !== ((k == 4) ? 4'b1110 : 4'b1101)) begin
                    n_errors++;
                    $display("FAIL reset_first_advance_edge%0d: an=%b expected %b", k, ifc.an,
                             (k == 4) ? 4'b1110 : 4'b1101);
                end
            end
        end
    endtask

    task automatic test_two_digit();
        logic [3:0] ea;
        logic [6:0] es;
        logic [3:0] an_tab [4];
        logic [6:0] seg_tab[4];
        int d;
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{7'b0110000, 7'b1111001, 7'b0011100, 7'b0011100};
        do_reset();
        ifc.value      = 4'd13;
        ifc.direction  = 1'b1;
        ifc.display_en = 1'b1;
        for (int k = 1; k <= 2 * Frame; k++) begin
            tick(ea, es);
            n_checks++;
            if (ifc.an !== ea || ifc.seg !== es) begin
                n_errors++;
                $display("FAIL two_digit_model_%0d: an=%b seg=%b expected an=%b seg=%b", k, ifc.an,
                         ifc.seg, ea, es);
            end
            if (k > Frame && (k - Frame - 1) % Dwell == 0) begin
                d = (k - Frame - 1) / Dwell;
                n_checks++;
                if (ifc.an !== an_tab[d] || ifc.seg !== seg_tab[d]) begin
                    n_errors++;
                    $display("FAIL two_digit_digit%0d: an=%b seg=%b expected an=%b seg=%b", d,
                             ifc.an, ifc.seg, an_tab[d], seg_tab[d]);
                end
            end
        end
    endtask

    task automatic test_blank_dir();
        logic [3:0] ea;
        logic [6:0] es;
        logic [6:0] seg_tab[4];
        int d;
        seg_tab = '{7'b1111000, 7'b1111111, 7'b0100011, 7'b0100011};
        do_reset();
        ifc.value      = 4'd7;
        ifc.direction  = 1'b0;
        ifc.display_en = 1'b1;
        for (int k = 1; k <= 2 * Frame; k++) begin
            tick(ea, es);
            n_checks++;
            if (ifc.an !== ea || ifc.seg !== es) begin
                n_errors++;
                $display("FAIL blank_dir_model_%0d: an=%b seg=%b expected an=%b seg=%b", k, ifc.an,
                         ifc.seg, ea, es);
            end
            if (k > Frame && (k - Frame - 1) % Dwell == 0) begin
                d = (k - Frame - 1) / Dwell;
                n_checks++;
                if (ifc.seg !== seg_tab[d]) begin
                    n_errors++;
                    $display("FAIL blank_dir_digit%0d: seg=%b expected %b", d, ifc.seg, seg_tab[d]);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        logic [3:0] ea;
        logic [6:0] es;
        logic [6:0] f2_tab[4];
        logic [6:0] f3_tab[4];
        int d;
        f2_tab = '{7'b0010010, 7'b1111111, 7'b0011100, 7'b0011100};
        f3_tab = '{7'b0100100, 7'b1111001, 7'b0011100, 7'b0011100};
        do_reset();
        ifc.value      = 4'd5;
        ifc.direction  = 1'b1;
        ifc.display_en = 1'b1;
        for (int k = 1; k <= 3 * Frame; k++) begin
            // Digit 1 of the second frame is lit from edge Frame+Dwell+1 onward.
            if (k == Frame + Dwell + 3) ifc.value = 4'd12;
            tick(ea, es);
            n_checks++;
            if (ifc.an !== ea || ifc.seg !== es) begin
                n_errors++;
                $display("FAIL snapshot_model_%0d: an=%b seg=%b expected an=%b seg=%b", k, ifc.an,
                         ifc.seg, ea, es);
            end
            if (k > Frame && (k - 1) % Dwell == 0) begin
                d = ((k - 1) / Dwell) % 4;
                n_checks++;
                if (k <= 2 * Frame && ifc.seg !== f2_tab[d]) begin
                    n_errors++;
                    $display("FAIL snapshot_old_digit%0d: seg=%b expected %b", d, ifc.seg, f2_tab[d]);
                end else if (k > 2 * Frame && ifc.seg !== f3_tab[d]) begin
                    n_errors++;
                    $display("FAIL snapshot_new_digit%0d: seg=%b expected %b", d, ifc.seg, f3_tab[d]);
                end
            end
        end
    endtask

    task automatic test_display_en();
        logic [3:0] ea;
        logic [6:0] es;
        do_reset();
        ifc.value      = 4'($urandom_range(0, 15));
        ifc.direction  = 1'($urandom_range(0, 1));
        ifc.display_en = 1'b1;
        for (int k = 1; k <= Frame + 3 + 6 + Frame; k++) begin
            if (k == Frame + 4)  ifc.display_en = 1'b0;
            if (k == Frame + 10) ifc.display_en = 1'b1;
            tick(ea, es);
            n_checks++;
            if (ifc.an !== ea || ifc.seg !== es) begin
                n_errors++;
                $display("FAIL display_en_model_%0d: an=%b seg=%b expected an=%b seg=%b", k, ifc.an,
                         ifc.seg, ea, es);
            end
            if (k >= Frame + 4 && k < Frame + 10) begin
                n_checks++;
                if (ifc.an !== 4'b1111) begin
                    n_errors++;
                    $display("FAIL display_en_off_%0d: an=%b expected 1111", k, ifc.an);
                end
            end
            if (k == Frame + 10) begin
                n_checks++;
                if (ifc.an !== 4'b1011) begin
                    n_errors++;
                    $display("FAIL display_en_resume: an=%b expected 1011", ifc.an);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] ea;
        logic [6:0] es;
        do_reset();
        ifc.value      = 4'd3;
        ifc.direction  = 1'b1;
        ifc.display_en = 1'b1;
        for (int k = 1; k <= 3 * Frame; k++) begin
            if (k == Frame) begin
                fork
                    begin
                        @(posedge clk);
                        ifc.value <= 4'd8;
                    end
                join_none
            end
            tick(ea, es);
            n_checks++;
            if (ifc.an !== ea || ifc.seg !== es) begin
                n_errors++;
                $display("FAIL simultaneous_model_%0d: an=%b seg=%b expected an=%b seg=%b", k,
                         ifc.an, ifc.seg, ea, es);
            end
            if (k == Frame + 1 || k == 2 * Frame + 1) begin
                n_checks++;
                if (ifc.seg !== ((k == Frame + 1) ? 7'b0110000 : 7'b0000000)) begin
                    n_errors++;
                    $display("FAIL simultaneous_digit0_edge%0d: seg=%b expected %b", k, ifc.seg,
                             (k == Frame + 1) ? 7'b0110000 : 7'b0000000);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] ea;
        logic [6:0] es;
        do_reset();
        ifc.display_en = 1'b1;
        repeat (8 * Frame) begin
            if ($urandom_range(0, 4) == 0) begin
                ifc.value     = 4'($urandom_range(0, 15));
                ifc.direction = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 7) == 0) ifc.display_en = ~ifc.display_en;
            tick(ea, es);
            n_checks++;
            if (ifc.an !== ea || ifc.seg !== es || ifc.dp !== 1'b1) begin
                n_errors++;
                $display("FAIL random_edge%0d: an=%b seg=%b dp=%b expected an=%b seg=%b dp=1",
                         m_edges, ifc.an, ifc.seg, ifc.dp, ea, es);
            end
        end
    endtask

    initial begin
        ifc.value      = 4'd0;
        ifc.direction  = 1'b1;
        ifc.display_en = 1'b1;
        test_reset();
        test_two_digit();
        test_blank_dir();
        test_snapshot();
        test_display_en();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
